// File: rtl/simple_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | simple_pkg                                                               |
// | Shared widths, opcode field encodings, branch condition codes and the    |
// | decoded-instruction record passed from decode to execute.                |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
package simple_pkg;

   localparam int DATA_W = 16;
   localparam int NREG   = 8;
   localparam int REG_AW = 3;

   // op[15:14]
   localparam logic [1:0] OP1_LD    = 2'b00;
   localparam logic [1:0] OP1_ST    = 2'b01;
   localparam logic [1:0] OP1_IMM   = 2'b10;
   localparam logic [1:0] OP1_ARITH = 2'b11;

   // op[13:11] when op1 = OP1_IMM
   localparam logic [2:0] OP2_LI  = 3'b000;
   localparam logic [2:0] OP2_B   = 3'b100;
   localparam logic [2:0] OP2_BCC = 3'b111;

   // op[7:4] when op1 = OP1_ARITH
   localparam logic [3:0] OP3_ADD   = 4'b0000;
   localparam logic [3:0] OP3_CMP   = 4'b0101;
   localparam logic [3:0] OP3_RSV_A = 4'b0111;
   localparam logic [3:0] OP3_OUT   = 4'b1101;
   localparam logic [3:0] OP3_RSV_B = 4'b1110;
   localparam logic [3:0] OP3_HLT   = 4'b1111;

   // Branch conditions; BCC carries its condition directly in op[10:8]
   localparam logic [2:0] COND_BE  = 3'b000;
   localparam logic [2:0] COND_BLT = 3'b001;
   localparam logic [2:0] COND_BLE = 3'b010;
   localparam logic [2:0] COND_BNE = 3'b011;

   typedef struct packed {
      logic [DATA_W-1:0] ar;
      logic [DATA_W-1:0] br;
      logic [DATA_W-1:0] imm;
      logic [REG_AW-1:0] rd;
      logic [3:0]        aluop;
      logic              regwrite;
      logic              memread;
      logic              memwrite;
      logic              isbranch;
      logic [2:0]        cond;
      logic [DATA_W-1:0] pcout;
      logic              valid;
   } dec_t;

   function automatic logic [DATA_W-1:0] sext8(input logic [7:0] d);
      return {{(DATA_W-8){d[7]}}, d};
   endfunction

endpackage
`default_nettype wire

// File: rtl/p2_decode_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | p2_decode_if                                                             |
// | Bundle between fetch/writeback/execute and the decode stage.             |
// |   inputs : operation, pcin, flush, wben, wbaddr, wbdata                  |
// |   outputs: ar, br, imm, rd, aluop, regwrite, memread, memwrite,          |
// |            isbranch, cond, pcout, valid, halted                          |
// | slave = decode stage side, master = surrounding pipeline / bench side.   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
interface p2_decode_if;
   import simple_pkg::*;

   logic [DATA_W-1:0] operation;
   logic [DATA_W-1:0] pcin;
   logic              flush;
   logic              wben;
   logic [REG_AW-1:0] wbaddr;
   logic [DATA_W-1:0] wbdata;

   logic [DATA_W-1:0] ar;
   logic [DATA_W-1:0] br;
   logic [DATA_W-1:0] imm;
   logic [REG_AW-1:0] rd;
   logic [3:0]        aluop;
   logic              regwrite;
   logic              memread;
   logic              memwrite;
   logic              isbranch;
   logic [2:0]        cond;
   logic [DATA_W-1:0] pcout;
   logic              valid;
   logic              halted;

   modport slave (
      input  operation, pcin, flush, wben, wbaddr, wbdata,
      output ar, br, imm, rd, aluop, regwrite, memread, memwrite,
             isbranch, cond, pcout, valid, halted
   );

   modport master (
      output operation, pcin, flush, wben, wbaddr, wbdata,
      input  ar, br, imm, rd, aluop, regwrite, memread, memwrite,
             isbranch, cond, pcout, valid, halted
   );

endinterface
`default_nettype wire

// File: rtl/p2_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | p2_regfile                                                               |
// | NREG x DATA_W general register file: one write port, two read ports.     |
// |   clk, rst           : clock, synchronous active-high clear             |
// |   we, waddr, wdata   : write port (r0 is an ordinary register)          |
// |   raddr_a/b, rdata_a/b: combinational reads with write-through bypass   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module p2_regfile #(
   parameter int DATA_W = 16,
   parameter int NREG   = 8,
   parameter int REG_AW = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [REG_AW-1:0] raddr_a,
   input  logic [REG_AW-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b
);

   logic [DATA_W-1:0] mem_q [NREG];
   logic [DATA_W-1:0] mem_d [NREG];

   always_comb begin
      mem_d = mem_q;
      if (we) begin
         mem_d[waddr] = wdata;
      end
   end

   // Reset clears everything and also blocks a concurrent write
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   // A write in the same cycle is forwarded so decode sees the new value
   always_comb begin
      rdata_a = (we && (waddr == raddr_a)) ? wdata : mem_q[raddr_a];
      rdata_b = (we && (waddr == raddr_b)) ? wdata : mem_q[raddr_b];
   end

endmodule
`default_nettype wire

// File: rtl/p2_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | p2_decode                                                                |
// | Decode / register-read stage. Decodes the fetched operation, reads two   |
// | operands from the owned register file and registers everything toward   |
// | execute with one cycle of latency. A decoded HLT sets a sticky halted    |
// | flag after which only bubbles are issued until reset.                    |
// |   clock1 : stage clock          reset : synchronous, active-high         |
// |   bus    : p2_decode_if.slave (fetch inputs, writeback, decoded outputs) |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module p2_decode
   import simple_pkg::*;
(
   input  logic        clock1,
   input  logic        reset,
   p2_decode_if.slave  bus
);

   logic [DATA_W-1:0] rdata_a;
   logic [DATA_W-1:0] rdata_b;

   p2_regfile #(
      .DATA_W (DATA_W),
      .NREG   (NREG),
      .REG_AW (REG_AW)
   ) u_regfile (
      .clk     (clock1),
      .rst     (reset),
      .we      (bus.wben),
      .waddr   (bus.wbaddr),
      .wdata   (bus.wbdata),
      .raddr_a (bus.operation[13:11]),
      .raddr_b (bus.operation[10:8]),
      .rdata_a (rdata_a),
      .rdata_b (rdata_b)
   );

   dec_t dec;
   logic is_hlt;
   dec_t out_d;
   dec_t out_q;
   logic halted_d;
   logic halted_q;

   // Field decode
   always_comb begin
      dec       = '0;
      is_hlt    = 1'b0;
      dec.ar    = rdata_a;
      dec.br    = rdata_b;
      dec.pcout = bus.pcin;
      dec.valid = 1'b1;
      case (bus.operation[15:14])
         OP1_ARITH: begin
            case (bus.operation[7:4])
               OP3_HLT:              is_hlt = 1'b1;
               OP3_RSV_A, OP3_RSV_B: ;   // reserved: issued as a valid no-op
               default: begin
                  dec.aluop    = bus.operation[7:4];
                  dec.rd       = bus.operation[10:8];
                  dec.regwrite = (bus.operation[7:4] != OP3_CMP) &&
                                 (bus.operation[7:4] != OP3_OUT);
                  // shifts (10xx) take a 4-bit unsigned amount
                  if (bus.operation[7:6] == 2'b10) begin
                     dec.imm = {{(DATA_W-4){1'b0}}, bus.operation[3:0]};
                  end
               end
            endcase
         end
         OP1_LD: begin
            dec.aluop    = OP3_ADD;
            dec.memread  = 1'b1;
            dec.regwrite = 1'b1;
            dec.rd       = bus.operation[13:11];
            dec.imm      = sext8(bus.operation[7:0]);
         end
         OP1_ST: begin
            dec.aluop    = OP3_ADD;
            dec.memwrite = 1'b1;
            dec.imm      = sext8(bus.operation[7:0]);
         end
         default: begin   // OP1_IMM
            case (bus.operation[13:11])
               OP2_LI: begin
                  dec.regwrite = 1'b1;
                  dec.rd       = bus.operation[10:8];
                  dec.imm      = sext8(bus.operation[7:0]);
               end
               OP2_B: begin
                  dec.isbranch = 1'b1;
                  dec.cond     = COND_BE;
                  dec.imm      = sext8(bus.operation[7:0]);
               end
               OP2_BCC: begin
                  dec.isbranch = 1'b1;
                  dec.cond     = bus.operation[10:8];
                  dec.imm      = sext8(bus.operation[7:0]);
               end
               default: ;   // unused op2 codes behave as a no-op
            endcase
         end
      endcase
   end

   // Flush beats halted, halted beats normal decode
   always_comb begin
      out_d    = dec;
      halted_d = halted_q;
      if (bus.flush || halted_q) begin
         out_d = '0;
      end else if (is_hlt) begin
         halted_d = 1'b1;
      end
   end

   always_ff @(posedge clock1) begin
      if (reset) begin
         out_q    <= '0;
         halted_q <= 1'b0;
      end else begin
         out_q    <= out_d;
         halted_q <= halted_d;
      end
   end

   assign bus.ar       = out_q.ar;
   assign bus.br       = out_q.br;
   assign bus.imm      = out_q.imm;
   assign bus.rd       = out_q.rd;
   assign bus.aluop    = out_q.aluop;
   assign bus.regwrite = out_q.regwrite;
   assign bus.memread  = out_q.memread;
   assign bus.memwrite = out_q.memwrite;
   assign bus.isbranch = out_q.isbranch;
   assign bus.cond     = out_q.cond;
   assign bus.pcout    = out_q.pcout;
   assign bus.valid    = out_q.valid;
   assign bus.halted   = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_p2_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_p2_decode                                                             |
// | Directed bench for the decode stage: each step drives one instruction    |
// | and writeback, pushes the expected registered outputs to a scoreboard    |
// | and pops/compares them one clock later.                                  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_p2_decode;
   import simple_pkg::*;

   logic clock1 = 1'b0;
   logic reset;

   always #5 clock1 = ~clock1;

   p2_decode_if bus ();

   p2_decode u_dut (
      .clock1 (clock1),
      .reset  (reset),
      .bus    (bus)
   );

   typedef struct packed {
      logic [15:0] ar;
      logic [15:0] br;
      logic [15:0] imm;
      logic [2:0]  rd;
      logic [3:0]  aluop;
      logic        regwrite;
      logic        memread;
      logic        memwrite;
      logic        isbranch;
      logic [2:0]  cond;
      logic [15:0] pcout;
      logic        valid;
      logic        halted;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   function automatic exp_t mk(input logic [15:0] ar, br, imm,
                               input logic [2:0] rd, input logic [3:0] aluop,
                               input logic rw, mr, mw, isb,
                               input logic [2:0] cond, input logic [15:0] pc,
                               input logic valid, halted);
      exp_t e;
      e.ar = ar;  e.br = br;  e.imm = imm;  e.rd = rd;  e.aluop = aluop;
      e.regwrite = rw;  e.memread = mr;  e.memwrite = mw;  e.isbranch = isb;
      e.cond = cond;  e.pcout = pc;  e.valid = valid;  e.halted = halted;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input int n);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL s%0d.sb: observed empty scoreboard expected one entry", n);
         return;
      end
      e = sb.pop_front();
      chk($sformatf("s%0d.ar", n),       bus.ar,              e.ar);
      chk($sformatf("s%0d.br", n),       bus.br,              e.br);
      chk($sformatf("s%0d.imm", n),      bus.imm,             e.imm);
      chk($sformatf("s%0d.rd", n),       16'(bus.rd),         16'(e.rd));
      chk($sformatf("s%0d.aluop", n),    16'(bus.aluop),      16'(e.aluop));
      chk($sformatf("s%0d.regwrite", n), 16'(bus.regwrite),   16'(e.regwrite));
      chk($sformatf("s%0d.memread", n),  16'(bus.memread),    16'(e.memread));
      chk($sformatf("s%0d.memwrite", n), 16'(bus.memwrite),   16'(e.memwrite));
      chk($sformatf("s%0d.isbranch", n), 16'(bus.isbranch),   16'(e.isbranch));
      chk($sformatf("s%0d.cond", n),     16'(bus.cond),       16'(e.cond));
      chk($sformatf("s%0d.pcout", n),    bus.pcout,           e.pcout);
      chk($sformatf("s%0d.valid", n),    16'(bus.valid),      16'(e.valid));
      chk($sformatf("s%0d.halted", n),   16'(bus.halted),     16'(e.halted));
   endtask

   // Drive one cycle of inputs, let the edge capture them, then compare
   task automatic step(input logic [15:0] op, input logic [15:0] pc, input logic fl,
                       input logic we, input logic [2:0] wa, input logic [15:0] wd,
                       input int n);
      bus.operation = op;
      bus.pcin      = pc;
      bus.flush     = fl;
      bus.wben      = we;
      bus.wbaddr    = wa;
      bus.wbdata    = wd;
      @(posedge clock1);
      #1;
      check_out(n);
   endtask

   initial begin
      exp_t z;
      exp_t hb;
      z  = mk(16'h0, 16'h0, 16'h0, 3'd0, 4'd0, 0, 0, 0, 0, 3'd0, 16'h0, 0, 0);
      hb = mk(16'h0, 16'h0, 16'h0, 3'd0, 4'd0, 0, 0, 0, 0, 3'd0, 16'h0, 0, 1);

      // Reset held two cycles while a write to r3 is attempted
      reset = 1'b1;
      sb.push_back(z);
      step(16'hD500, 16'h1111, 0, 1, 3'd3, 16'hFFFF, 1);
      sb.push_back(z);
      step(16'hD500, 16'h1111, 0, 1, 3'd3, 16'hFFFF, 2);
      reset = 1'b0;

      // ADD r3,r3: r3 must still be 0
      sb.push_back(mk(16'h0, 16'h0, 16'h0, 3'd3, 4'h0, 1, 0, 0, 0, 3'd0, 16'h0010, 1, 0));
      step(16'hDB00, 16'h0010, 0, 0, 3'd0, 16'h0, 3);

      // LD r0,0(r0) while writing r2 = 1234
      sb.push_back(mk(16'h0, 16'h0, 16'h0, 3'd0, 4'h0, 1, 1, 0, 0, 3'd0, 16'h0012, 1, 0));
      step(16'h0000, 16'h0012, 0, 1, 3'd2, 16'h1234, 4);

      // ADD r2,r5
      sb.push_back(mk(16'h1234, 16'h0, 16'h0, 3'd5, 4'h0, 1, 0, 0, 0, 3'd0, 16'h0014, 1, 0));
      step(16'hD500, 16'h0014, 0, 0, 3'd0, 16'h0, 5);

      // LD r1,4(r3) with same-cycle write r3 = BEEF (bypass)
      sb.push_back(mk(16'h0, 16'hBEEF, 16'h0004, 3'd1, 4'h0, 1, 1, 0, 0, 3'd0, 16'h0016, 1, 0));
      step(16'h0B04, 16'h0016, 0, 1, 3'd3, 16'hBEEF, 6);

      // LI r4,-2
      sb.push_back(mk(16'h0, 16'h0, 16'hFFFE, 3'd4, 4'h0, 1, 0, 0, 0, 3'd0, 16'h0018, 1, 0));
      step(16'h84FE, 16'h0018, 0, 0, 3'd0, 16'h0, 7);

      // Shift op3=1000, d=A: zero-extended imm
      sb.push_back(mk(16'hBEEF, 16'hBEEF, 16'h000A, 3'd3, 4'h8, 1, 0, 0, 0, 3'd0, 16'h001A, 1, 0));
      step(16'hDB8A, 16'h001A, 0, 0, 3'd0, 16'h0, 8);

      // ST r2,-128(r3)
      sb.push_back(mk(16'h1234, 16'hBEEF, 16'hFF80, 3'd0, 4'h0, 0, 0, 1, 0, 3'd0, 16'h001C, 1, 0));
      step(16'h5380, 16'h001C, 0, 0, 3'd0, 16'h0, 9);

      // CMP: no register write
      sb.push_back(mk(16'h1234, 16'hBEEF, 16'h0, 3'd3, 4'h5, 0, 0, 0, 0, 3'd0, 16'h001E, 1, 0));
      step(16'hD350, 16'h001E, 0, 0, 3'd0, 16'h0, 10);

      // BNE -3
      sb.push_back(mk(16'h0, 16'hBEEF, 16'hFFFD, 3'd0, 4'h0, 0, 0, 0, 1, 3'd3, 16'h0020, 1, 0));
      step(16'hBBFD, 16'h0020, 0, 0, 3'd0, 16'h0, 11);

      // Flush with concurrent write r7 = 5A5A
      sb.push_back(z);
      step(16'hD500, 16'h0022, 1, 1, 3'd7, 16'h5A5A, 12);

      // ADD r7,r7: the flushed-cycle write landed
      sb.push_back(mk(16'h5A5A, 16'h5A5A, 16'h0, 3'd7, 4'h0, 1, 0, 0, 0, 3'd0, 16'h0024, 1, 0));
      step(16'hFF00, 16'h0024, 0, 0, 3'd0, 16'h0, 13);

      // ADD r0,r0 with bypassed write r0 = 0001 (r0 is writable)
      sb.push_back(mk(16'h0001, 16'h0001, 16'h0, 3'd0, 4'h0, 1, 0, 0, 0, 3'd0, 16'h0026, 1, 0));
      step(16'hC000, 16'h0026, 0, 1, 3'd0, 16'h0001, 14);

      // HLT
      sb.push_back(mk(16'h0001, 16'h0001, 16'h0, 3'd0, 4'h0, 0, 0, 0, 0, 3'd0, 16'h0028, 1, 1));
      step(16'hC0F0, 16'h0028, 0, 0, 3'd0, 16'h0, 15);

      // Halted: bubbles only
      sb.push_back(hb);
      step(16'hD500, 16'h002A, 0, 1, 3'd5, 16'h0F0F, 16);
      sb.push_back(hb);
      step(16'h84FE, 16'h002C, 0, 0, 3'd0, 16'h0, 17);
      sb.push_back(hb);
      step(16'hBBFD, 16'h002E, 1, 0, 3'd0, 16'h0, 18);

      // Reset clears halted and registers
      reset = 1'b1;
      sb.push_back(z);
      step(16'hD500, 16'h0030, 0, 0, 3'd0, 16'h0, 19);
      reset = 1'b0;

      sb.push_back(mk(16'h0, 16'h0, 16'h0, 3'd5, 4'h0, 1, 0, 0, 0, 3'd0, 16'h0032, 1, 0));
      step(16'hD500, 16'h0032, 0, 0, 3'd0, 16'h0, 20);

      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL sb_drain: observed %0d entries expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
